// File: rtl/rram_pkg.sv
// Shared definitions for the cache->RRAM write sequencer: address widths,
// FSM state encoding and a small state-classification helper.
package rram_pkg;

   localparam int RRAM_ADDR_W  = 5;
   localparam int CACHE_ADDR_W = 5;

   // ST_START is the one-cycle decision slot after capture, where the
   // sequencer picks the first non-empty pulse phase.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_SET_PH = 3'd2,
      ST_RST_PH = 3'd3,
      ST_VERIFY = 3'd4,
      ST_CHECK  = 3'd5
   } wseq_state_e;

   // True for the two states that drive timed pulses into the array.
   function automatic logic is_pulse_state(input wseq_state_e st);
      return (st == ST_SET_PH) || (st == ST_RST_PH);
   endfunction

endpackage

// File: rtl/rram_write_sequencer_if.sv
// Cache-side request/completion handshake plus RRAM array pulse/read bus.
// slave = sequencer view, master = cache/array environment view.
interface rram_write_sequencer_if
   import rram_pkg::*;
#(
   parameter int DATA_W = 8
) ();

   logic                    req;
   logic [CACHE_ADDR_W-1:0] cache_add;
   logic [RRAM_ADDR_W-1:0]  reg_add;
   logic [DATA_W-1:0]       wr_data;
   logic [DATA_W-1:0]       rd_data;
   logic                    ack;
   logic                    busy;
   logic [RRAM_ADDR_W-1:0]  arr_addr;
   logic [DATA_W-1:0]       set_en;
   logic [DATA_W-1:0]       rst_en;
   logic                    arr_re;
   logic                    done;
   logic                    fail;
   logic [CACHE_ADDR_W-1:0] done_slot;

   modport slave (
      input  req, cache_add, reg_add, wr_data, rd_data,
      output ack, busy, arr_addr, set_en, rst_en, arr_re, done, fail, done_slot
   );

   modport master (
      output req, cache_add, reg_add, wr_data, rd_data,
      input  ack, busy, arr_addr, set_en, rst_en, arr_re, done, fail, done_slot
   );

endinterface

// File: rtl/rram_pulse_timer.sv
// Pulse-width timer shared by the SET and RESET phases. i_load restarts a
// PULSE_CYC-long window beginning next cycle; o_last flags its final cycle.
module rram_pulse_timer #(
   parameter int PULSE_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   output logic o_last
);

   localparam int               CNT_W    = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_last;

   // load on phase entry, otherwise count down and hold at zero
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_load) begin
         w_cnt_nxt = LOAD_VAL;
      end else if (r_cnt != CNT_ZERO) begin
         w_cnt_nxt = r_cnt - CNT_W'(1'b1);
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // counter and registered last-cycle flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= CNT_ZERO;
         r_last <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_last <= (w_cnt_nxt == CNT_ZERO);
      end
   end

   assign o_last = r_last;

endmodule

// File: rtl/rram_write_sequencer.sv
// Programs one cache word into an RRAM register with timed SET/RESET pulses.
// Build option RRAM_VERIFY_EN adds read-verify with re-pulsing of failing
// bits (up to MAX_RETRY extra rounds); without it the word is reported done
// right after the pulse phases, with fail and arr_re tied low.
module rram_write_sequencer
   import rram_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int PULSE_CYC = 4
`ifdef RRAM_VERIFY_EN
   , parameter int MAX_RETRY = 3
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rram_write_sequencer_if.slave bus
);

   localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};

`ifdef RRAM_VERIFY_EN
   localparam int                 RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
   localparam wseq_state_e        PULSE_EXIT = ST_VERIFY;
   logic [RETRY_W-1:0] r_retry;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  w_err;
   logic               w_retry_inc;
   logic               w_fail_nxt;
   logic               r_fail;
   logic               r_arr_re;
`else
   localparam wseq_state_e        PULSE_EXIT = ST_IDLE;
`endif

   wseq_state_e             r_state;
   wseq_state_e             w_state_nxt;
   logic [CACHE_ADDR_W-1:0] r_slot;
   logic [RRAM_ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]       r_pend_set;
   logic [DATA_W-1:0]       r_pend_rst;
   logic [DATA_W-1:0]       w_pend_set_nxt;
   logic [DATA_W-1:0]       w_pend_rst_nxt;
   logic [DATA_W-1:0]       r_set_en;
   logic [DATA_W-1:0]       r_rst_en;
   logic                    w_capture;
   logic                    w_done_nxt;
   logic                    w_load;
   logic                    w_last;
   logic                    r_ack;
   logic                    r_busy;
   logic                    r_done;

   rram_pulse_timer #(.PULSE_CYC(PULSE_CYC)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .o_last (w_last)
   );

   // next-state, pending pulse masks and completion decode
   always_comb begin
      w_state_nxt    = r_state;
      w_pend_set_nxt = r_pend_set;
      w_pend_rst_nxt = r_pend_rst;
      w_capture      = 1'b0;
`ifdef RRAM_VERIFY_EN
      w_err          = ZERO_W;
      w_retry_inc    = 1'b0;
      w_fail_nxt     = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            // r_busy still high in the done cycle keeps a waiting req out
            if (bus.req && !r_busy) begin
               w_capture      = 1'b1;
               w_pend_set_nxt = bus.wr_data;
               w_pend_rst_nxt = ~bus.wr_data;
               w_state_nxt    = ST_START;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_START: begin
            if (r_pend_set != ZERO_W) begin
               w_state_nxt = ST_SET_PH;
            end else if (r_pend_rst != ZERO_W) begin
               w_state_nxt = ST_RST_PH;
            end else begin
               w_state_nxt = PULSE_EXIT;
            end
         end
         ST_SET_PH: begin
            if (w_last) begin
               if (r_pend_rst != ZERO_W) begin
                  w_state_nxt = ST_RST_PH;
               end else begin
                  w_state_nxt = PULSE_EXIT;
               end
            end else begin
               w_state_nxt = ST_SET_PH;
            end
         end
         ST_RST_PH: begin
            if (w_last) begin
               w_state_nxt = PULSE_EXIT;
            end else begin
               w_state_nxt = ST_RST_PH;
            end
         end
`ifdef RRAM_VERIFY_EN
         ST_VERIFY: begin
            w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            w_err = bus.rd_data ^ r_wdata;
            if (w_err == ZERO_W) begin
               w_state_nxt = ST_IDLE;
            end else if (r_retry < RETRY_MAX) begin
               // re-pulse only the bits that read back wrong
               w_retry_inc    = 1'b1;
               w_pend_set_nxt = w_err & r_wdata;
               w_pend_rst_nxt = w_err & ~r_wdata;
               if ((w_err & r_wdata) != ZERO_W) begin
                  w_state_nxt = ST_SET_PH;
               end else begin
                  w_state_nxt = ST_RST_PH;
               end
            end else begin
               w_state_nxt = ST_IDLE;
               w_fail_nxt  = 1'b1;
            end
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_done_nxt = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
      w_load     = is_pulse_state(w_state_nxt) && (w_state_nxt != r_state);
   end

   // FSM state, captured request fields and pending masks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_slot     <= {CACHE_ADDR_W{1'b0}};
         r_addr     <= {RRAM_ADDR_W{1'b0}};
         r_pend_set <= ZERO_W;
         r_pend_rst <= ZERO_W;
      end else begin
         r_state    <= w_state_nxt;
         r_pend_set <= w_pend_set_nxt;
         r_pend_rst <= w_pend_rst_nxt;
         if (w_capture) begin
            r_slot <= bus.cache_add;
            r_addr <= bus.reg_add;
         end
      end
   end

   // registered outputs decoded from the next state so set/rst never overlap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack    <= 1'b0;
         r_busy   <= 1'b0;
         r_set_en <= ZERO_W;
         r_rst_en <= ZERO_W;
         r_done   <= 1'b0;
      end else begin
         r_ack    <= w_capture;
         r_busy   <= (w_state_nxt != ST_IDLE) || w_done_nxt;
         r_set_en <= (w_state_nxt == ST_SET_PH) ? w_pend_set_nxt : ZERO_W;
         r_rst_en <= (w_state_nxt == ST_RST_PH) ? w_pend_rst_nxt : ZERO_W;
         r_done   <= w_done_nxt;
      end
   end

`ifdef RRAM_VERIFY_EN
   // verify-path registers: target word, retry count, read strobe, fail flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdata  <= ZERO_W;
         r_retry  <= {RETRY_W{1'b0}};
         r_arr_re <= 1'b0;
         r_fail   <= 1'b0;
      end else begin
         r_arr_re <= (w_state_nxt == ST_VERIFY);
         r_fail   <= w_fail_nxt;
         if (w_capture) begin
            r_wdata <= bus.wr_data;
            r_retry <= {RETRY_W{1'b0}};
         end else if (w_retry_inc) begin
            r_retry <= r_retry + RETRY_W'(1'b1);
         end else begin
            r_retry <= r_retry;
         end
      end
   end

   assign bus.arr_re = r_arr_re;
   assign bus.fail   = r_fail;
`else
   assign bus.arr_re = 1'b0;
   assign bus.fail   = 1'b0;
`endif

   assign bus.ack       = r_ack;
   assign bus.busy      = r_busy;
   assign bus.arr_addr  = r_addr;
   assign bus.set_en    = r_set_en;
   assign bus.rst_en    = r_rst_en;
   assign bus.done      = r_done;
   assign bus.done_slot = r_slot;

endmodule

// File: tb/tb_rram_write_sequencer.sv
// Directed self-checking bench for rram_write_sequencer (DATA_W=8,
// PULSE_CYC=4, MAX_RETRY=3). Expectations follow RRAM_VERIFY_EN.
module tb_rram_write_sequencer;
   import rram_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   rram_write_sequencer_if #(.DATA_W(8)) bus ();

   rram_write_sequencer #(
      .DATA_W    (8),
      .PULSE_CYC (4)
`ifdef RRAM_VERIFY_EN
      , .MAX_RETRY (3)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] rd_q[$];
   int         t_lat, t_nset, t_nrst, t_nre, t_overlap, t_ackx, t_busy_gap;
   logic [7:0] t_first_set, t_last_set, t_first_rst;
   logic       t_fail;
   logic [4:0] t_slot, t_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request (called at a negedge) and monitor until done.
   task automatic txn(input logic [7:0] wd, input logic [4:0] slot, input logic [4:0] addr);
      logic got_ack;
      got_ack = 1'b0;
      t_lat = -1; t_nset = 0; t_nrst = 0; t_nre = 0; t_overlap = 0; t_ackx = 0; t_busy_gap = 0;
      t_first_set = 8'h00; t_last_set = 8'h00; t_first_rst = 8'h00;
      t_fail = 1'b0; t_slot = 5'd0; t_addr = 5'd0;
      bus.wr_data   = wd;
      bus.cache_add = slot;
      bus.reg_add   = addr;
      bus.req       = 1'b1;
      for (int i = 0; i < 20 && !got_ack; i++) begin
         @(negedge clk);
         if (bus.ack === 1'b1) got_ack = 1'b1;
      end
      bus.req = 1'b0;
      chk("ack_seen", {31'd0, got_ack}, 32'd1);
      if (!got_ack) return;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (bus.ack === 1'b1) t_ackx++;
         if (bus.busy !== 1'b1) t_busy_gap++;
         if (bus.set_en != 8'h00) begin
            if (t_nset == 0) t_first_set = bus.set_en;
            t_last_set = bus.set_en;
            t_addr     = bus.arr_addr;
            t_nset++;
         end
         if (bus.rst_en != 8'h00) begin
            if (t_nrst == 0) t_first_rst = bus.rst_en;
            t_addr = bus.arr_addr;
            t_nrst++;
         end
         if ((bus.set_en != 8'h00) && (bus.rst_en != 8'h00)) t_overlap++;
         if (bus.arr_re === 1'b1) begin
            t_nre++;
            if (rd_q.size() > 0) bus.rd_data = rd_q.pop_front();
         end
         if (bus.done === 1'b1) begin
            t_lat  = k;
            t_fail = bus.fail;
            t_slot = bus.done_slot;
            break;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic got;
      rst_n = 1'b0;
      bus.req = 1'b0; bus.cache_add = 5'd0; bus.reg_add = 5'd0;
      bus.wr_data = 8'h00; bus.rd_data = 8'h00;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_ack",    {31'd0, bus.ack},    32'd0);
      chk("rst_busy",   {31'd0, bus.busy},   32'd0);
      chk("rst_done",   {31'd0, bus.done},   32'd0);
      chk("rst_fail",   {31'd0, bus.fail},   32'd0);
      chk("rst_arr_re", {31'd0, bus.arr_re}, 32'd0);
      chk("rst_set_en", {24'd0, bus.set_en}, 32'd0);
      chk("rst_rst_en", {24'd0, bus.rst_en}, 32'd0);
      chk("rst_addr",   {27'd0, bus.arr_addr},  32'd0);
      chk("rst_slot",   {27'd0, bus.done_slot}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // word A5: both phases, first-try verify pass
      rd_q = '{8'hA5};
      txn(8'hA5, 5'd3, 5'd7);
      chk("a5_nset",  t_nset, 32'd4);
      chk("a5_set",   {24'd0, t_first_set}, 32'hA5);
      chk("a5_nrst",  t_nrst, 32'd4);
      chk("a5_rst",   {24'd0, t_first_rst}, 32'h5A);
      chk("a5_ovl",   t_overlap, 32'd0);
      chk("a5_ackx",  t_ackx, 32'd0);
      chk("a5_busy",  t_busy_gap, 32'd0);
      chk("a5_addr",  {27'd0, t_addr}, 32'd7);
      chk("a5_slot",  {27'd0, t_slot}, 32'd3);
      chk("a5_fail",  {31'd0, t_fail}, 32'd0);
`ifdef RRAM_VERIFY_EN
      chk("a5_lat",   t_lat, 32'd11);
      chk("a5_nre",   t_nre, 32'd1);
`else
      chk("a5_lat",   t_lat, 32'd9);
      chk("a5_nre",   t_nre, 32'd0);
`endif

      // word FF requested back-to-back from the done cycle: RESET skipped
      rd_q = '{8'hFF};
      txn(8'hFF, 5'd9, 5'd2);
      chk("ff_nset", t_nset, 32'd4);
      chk("ff_set",  {24'd0, t_last_set}, 32'hFF);
      chk("ff_nrst", t_nrst, 32'd0);
      chk("ff_slot", {27'd0, t_slot}, 32'd9);
`ifdef RRAM_VERIFY_EN
      chk("ff_lat",  t_lat, 32'd7);
`else
      chk("ff_lat",  t_lat, 32'd5);
`endif
      @(negedge clk);
      chk("ff_idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("ff_idle_done", {31'd0, bus.done}, 32'd0);

`ifdef RRAM_VERIFY_EN
      // word F0, first read E0: one retry pulsing only bit 4 with SET
      rd_q = '{8'hE0, 8'hF0};
      txn(8'hF0, 5'd17, 5'd11);
      chk("f0_nset",  t_nset, 32'd8);
      chk("f0_first", {24'd0, t_first_set}, 32'hF0);
      chk("f0_retry", {24'd0, t_last_set}, 32'h10);
      chk("f0_nrst",  t_nrst, 32'd4);
      chk("f0_nre",   t_nre, 32'd2);
      chk("f0_lat",   t_lat, 32'd17);
      chk("f0_fail",  {31'd0, t_fail}, 32'd0);
      @(negedge clk);

      // word 0F, read stuck at 00: four SET rounds then fail with done
      rd_q = '{8'h00};
      txn(8'h0F, 5'd30, 5'd31);
      chk("0f_nset", t_nset, 32'd16);
      chk("0f_set",  {24'd0, t_last_set}, 32'h0F);
      chk("0f_nrst", t_nrst, 32'd4);
      chk("0f_nre",  t_nre, 32'd4);
      chk("0f_lat",  t_lat, 32'd29);
      chk("0f_fail", {31'd0, t_fail}, 32'd1);
      chk("0f_slot", {27'd0, t_slot}, 32'd30);
      @(negedge clk);
`else
      // word 3C: both phases, no verify read
      txn(8'h3C, 5'd17, 5'd11);
      chk("3c_set",  {24'd0, t_first_set}, 32'h3C);
      chk("3c_rst",  {24'd0, t_first_rst}, 32'hC3);
      chk("3c_nre",  t_nre, 32'd0);
      chk("3c_lat",  t_lat, 32'd9);
      chk("3c_fail", {31'd0, t_fail}, 32'd0);
      @(negedge clk);

      // word 00: SET skipped
      txn(8'h00, 5'd30, 5'd31);
      chk("00_nset", t_nset, 32'd0);
      chk("00_rst",  {24'd0, t_first_rst}, 32'hFF);
      chk("00_lat",  t_lat, 32'd5);
      @(negedge clk);
`endif

      // reset asserted in the middle of SET_PH
      bus.wr_data = 8'h5A; bus.cache_add = 5'd5; bus.reg_add = 5'd6; bus.req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus.ack === 1'b1) got = 1'b1;
      end
      bus.req = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (bus.set_en != 8'h00) got = 1'b1;
      end
      chk("mid_set_en", {24'd0, bus.set_en}, 32'h5A);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_set_en", {24'd0, bus.set_en}, 32'd0);
      chk("mid_rst_busy",   {31'd0, bus.busy},   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", {31'd0, bus.busy},   32'd0);
      chk("post_rst_set",  {24'd0, bus.set_en}, 32'd0);

      // normal request after reset release
      rd_q = '{8'h81};
      txn(8'h81, 5'd12, 5'd4);
      chk("re_set",  {24'd0, t_first_set}, 32'h81);
      chk("re_rst",  {24'd0, t_first_rst}, 32'h7E);
      chk("re_slot", {27'd0, t_slot}, 32'd12);
`ifdef RRAM_VERIFY_EN
      chk("re_lat",  t_lat, 32'd11);
`else
      chk("re_lat",  t_lat, 32'd9);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
